branch_hazard_unit: RTL

- Parametrised successor to the single-stage branch forwarder: resolves operand hazards for branches evaluated in ID.
- Selects forwarding from MEM or WB per source operand.
- Generates multi-cycle ID stalls through a counting FSM when a producer in EX, or a load in MEM, cannot yet supply the value.
- Keeps saturating stall and forward event counters for performance analysis.
- Sits beside the main hazard unit. Drives the ID-stage branch comparator muxes, the PC/IF-ID hold, and the ID/EX bubble insert.

---
 rtl/branch_hazard_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/branch_hazard_unit.sv
// Branch operand hazard unit for branches resolved in ID.
// Chooses per-operand forwarding from MEM or WB and holds ID for one or two
// cycles when a producer in EX, or a load in MEM, cannot supply the value yet.
// Saturating counters record stall cycles and forwarded branches.
module branch_hazard_unit #(
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 16,
    parameter bit          WB_FWD = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_branch,
    input  logic             id_use_Rb,
    input  logic [REG_W-1:0] id_Ra,
    input  logic [REG_W-1:0] id_Rb,
    input  logic             id_flush,
    input  logic [REG_W-1:0] ex_Rw,
    input  logic             ex_RegWr,
    input  logic             ex_MemtoReg,
    input  logic [REG_W-1:0] mem_Rw,
    input  logic             mem_RegWr,
    input  logic             mem_MemtoReg,
    input  logic [REG_W-1:0] wb_Rw,
    input  logic             wb_RegWr,
    output logic [1:0]       BranchForwardA,
    output logic [1:0]       BranchForwardB,
    output logic             stall_id,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] fwd_cnt
);

    typedef enum logic {StIdle, StStall} state_e;

    state_e           state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

    logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
    logic [1:0] need;

    // Source/producer matches; r0 never matches, B only when the branch reads it
    always_comb begin
        ex_a  = id_branch && ex_RegWr  && (ex_Rw  != '0) && (ex_Rw  == id_Ra);
        ex_b  = id_branch && id_use_Rb && ex_RegWr  && (ex_Rw  != '0) && (ex_Rw  == id_Rb);
        mem_a = id_branch && mem_RegWr && (mem_Rw != '0) && (mem_Rw == id_Ra);
        mem_b = id_branch && id_use_Rb && mem_RegWr && (mem_Rw != '0) && (mem_Rw == id_Rb);
        wb_a  = id_branch && wb_RegWr  && (wb_Rw  != '0) && (wb_Rw  == id_Ra);
        wb_b  = id_branch && id_use_Rb && wb_RegWr  && (wb_Rw  != '0) && (wb_Rw  == id_Rb);
    end

    // Stall cycles still required, worst case over the active sources
    always_comb begin
        need = 2'd0;
        if ((ex_a || ex_b) && ex_MemtoReg) begin
            need = 2'd2;
        end else if (ex_a || ex_b) begin
            need = 2'd1;
        end else if ((mem_a || mem_b) && mem_MemtoReg) begin
            need = 2'd1;
        end
    end

    // Stall output; reset and flush drop it without waiting for an edge
    always_comb begin
        stall_id = !rst && !id_flush && ((state_q == StStall) || (need != 2'd0));
    end

    // Next state: the first stall cycle is spent in IDLE, the remainder in STALL
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (id_flush) begin
            state_d = StIdle;
            rem_d   = 2'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (need > 2'd1) begin
                        state_d = StStall;
                        rem_d   = need - 2'd1;
                    end else begin
                        state_d = StIdle;
                        rem_d   = 2'd0;
                    end
                end
                StStall: begin
                    if (rem_q <= 2'd1) begin
                        state_d = StIdle;
                        rem_d   = 2'd0;
                    end else begin
                        rem_d   = rem_q - 2'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    rem_d   = 2'd0;
                end
            endcase
        end
    end

    // Forward selects: MEM ALU result beats WB; nothing forwards while stalled
    always_comb begin
        BranchForwardA = 2'd0;
        BranchForwardB = 2'd0;
        if (!stall_id) begin
            if (mem_a && !mem_MemtoReg) begin
                BranchForwardA = 2'd1;
            end else if (WB_FWD && wb_a) begin
                BranchForwardA = 2'd2;
            end
            if (mem_b && !mem_MemtoReg) begin
                BranchForwardB = 2'd1;
            end else if (WB_FWD && wb_b) begin
                BranchForwardB = 2'd2;
            end
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall_id && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (id_branch && !stall_id && ((BranchForwardA != 2'd0) || (BranchForwardB != 2'd0))
            && (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
        end
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rem_q       <= 2'd0;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;

endmodule
